// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM encoding, status bit positions and frame constants.
package uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } tx_state_t;

   localparam int BUSY  = 0;
   localparam int FULL  = 1;
   localparam int EMPTY = 2;
   localparam int OVF   = 3;

   localparam int CLR_BIT    = 31;
   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the serialiser; extra pointer MSB
// separates full from empty.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_pop;
   logic        do_push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop on the same edge frees the slot a full-FIFO push needs
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign dout = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: store decode, TX FIFO,
// bit-timing FSM and a combinational status word.
module uart_tx_peripheral
   import uart_pkg::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic                   enableUART,
   input  logic [WORD_LENGTH-1:0] data,
   output logic [WORD_LENGTH-1:0] status,
   output logic                   uart_tx,
   output logic                   tx_done
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   tx_state_t     state;
   tx_state_t     state_d;
   logic [BW-1:0] baud_cnt;
   logic [BW-1:0] baud_d;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_d;
   logic [7:0]    shift_reg;
   logic [7:0]    shift_d;
   logic          ovf;
   logic          ovf_d;
   logic          done_d;
   logic          baud_last;

   logic       wr;
   logic       clr;
   logic       push_req;
   logic       pop;
   logic       full;
   logic       empty;
   logic [7:0] fifo_dout;
   logic       unused_bits;

   assign wr       = we & enableUART;
   assign clr      = wr & data[CLR_BIT];
   assign push_req = wr & ~data[CLR_BIT];
   assign unused_bits = ^data;

   uart_tx_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push_req),
      .pop  (pop),
      .din  (data[7:0]),
      .dout (fifo_dout),
      .full (full),
      .empty(empty)
   );

   assign baud_last = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         ovf       <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_d;
         baud_cnt  <= baud_d;
         bit_cnt   <= bit_d;
         shift_reg <= shift_d;
         ovf       <= ovf_d;
         tx_done   <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      baud_d  = baud_cnt;
      bit_d   = bit_cnt;
      shift_d = shift_reg;
      done_d  = 1'b0;
      pop     = 1'b0;
      if (state != IDLE) begin
         baud_d = baud_last ? '0 : baud_cnt + 1'b1;
      end
      unique case (state)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               state_d = START;
            end
         end
         START: begin
            if (baud_last) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_last) begin
               shift_d = {1'b0, shift_reg[7:1]};
               bit_d   = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Overflow is sticky; only an explicit clear command drops it
   always_comb begin
      ovf_d = ovf;
      if (clr) begin
         ovf_d = 1'b0;
      end else if (push_req && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   always_comb begin
      uart_tx = 1'b1;
      unique case (state)
         START:   uart_tx = 1'b0;
         DATA:    uart_tx = shift_reg[0];
         default: uart_tx = 1'b1;
      endcase
   end

   always_comb begin
      status        = '0;
      status[BUSY]  = (state != IDLE);
      status[FULL]  = full;
      status[EMPTY] = empty;
      status[OVF]   = ovf;
   end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Self-checking bench: frame-timeline model, line receiver and
// directed scenarios for the UART transmitter peripheral.
module tb_uart_tx_peripheral;

   localparam int BD = 16;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic        enableUART;
   logic [31:0] data;
   logic [31:0] status;
   logic        uart_tx;
   logic        tx_done;

   int errors = 0;
   int checks = 0;

   uart_tx_peripheral #(
      .WORD_LENGTH(32),
      .CLK_FREQ   (16),
      .BAUD_RATE  (1),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .enableUART(enableUART),
      .data      (data),
      .status    (status),
      .uart_tx   (uart_tx),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Model: a byte queue plus the edge index at which the current
   // frame began; the line value follows from the offset into it.
   logic [7:0] mq[$];
   logic [7:0] m_cur = 8'h00;
   logic       m_busy = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_done = 1'b0;
   int         cyc = 0;
   int         m_start = 0;

   task automatic model_step();
      logic pop_now;
      logic fin;
      if (reset) begin
         mq.delete();
         m_busy = 1'b0;
         m_ovf  = 1'b0;
         m_done = 1'b0;
         cyc    = 0;
      end else begin
         cyc++;
         pop_now = !m_busy && (mq.size() > 0);
         fin = m_busy && (cyc - m_start == 10 * BD);
         m_done = fin;
         if (pop_now) begin
            m_cur   = mq.pop_front();
            m_busy  = 1'b1;
            m_start = cyc;
         end
         if (we && enableUART) begin
            if (data[31]) m_ovf = 1'b0;
            else if (mq.size() < DEPTH) mq.push_back(data[7:0]);
            else m_ovf = 1'b1;
         end
         if (fin) m_busy = 1'b0;
      end
   endtask

   function automatic logic exp_line();
      int b;
      if (!m_busy) return 1'b1;
      b = (cyc - m_start) / BD;
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[0] = m_busy;
      s[1] = (mq.size() == DEPTH);
      s[2] = (mq.size() == 0);
      s[3] = m_ovf;
      return s;
   endfunction

   always @(posedge clk or posedge reset) model_step();

   task automatic compare_step();
      if (!reset) begin
         chk("line", 32'(uart_tx), 32'(exp_line()));
         chk("tx_done", 32'(tx_done), 32'(m_done));
         chk("status", status, exp_status());
      end
   endtask

   always @(negedge clk) compare_step();

   // Line receiver sampling mid-bit
   logic [7:0] rx_q[$];
   logic [7:0] rx_sh = 8'h00;
   logic       rx_on = 1'b0;
   int         rx_k = 0;

   task automatic rx_step();
      if (reset) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (uart_tx == 1'b0) begin
            rx_on = 1'b1;
            rx_k  = 0;
         end
      end else begin
         rx_k++;
         if ((rx_k % BD == BD / 2) && rx_k >= 24 && rx_k <= 136)
            rx_sh = {uart_tx, rx_sh[7:1]};
         if (rx_k == 9 * BD + BD / 2) begin
            chk("stop_bit", 32'(uart_tx), 32'h1);
            rx_q.push_back(rx_sh);
            rx_on = 1'b0;
         end
      end
   endtask

   always @(negedge clk) rx_step();

   task automatic wr(input logic [31:0] d);
      we = 1'b1;
      enableUART = 1'b1;
      data = d;
      @(negedge clk);
   endtask

   task automatic idle_bus();
      we = 1'b0;
      enableUART = 1'b0;
      data = '0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (!(status[0] == 1'b0 && status[2] == 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL wait_idle: got timeout expected idle in %0d", limit);
      end
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (tx_done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL wait_done: got timeout expected pulse in %0d", limit);
      end
   endtask

   task automatic rx_expect(input string name, input logic [7:0] b);
      logic [7:0] got;
      checks++;
      if (rx_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got no byte expected %h", name, b);
      end else begin
         got = rx_q.pop_front();
         if (got !== b) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, b);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_bus();
      repeat (3) @(negedge clk);
      chk("rst_line", 32'(uart_tx), 32'h1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_status", status, 32'h4);
      chk("rst_done", 32'(tx_done), 32'h0);

      // Reset in the middle of a start bit
      wr(32'h0F);
      idle_bus();
      chk("rst_pre_start", 32'(uart_tx), 32'h1);
      @(negedge clk);
      repeat (5) @(negedge clk);
      chk("rst_mid_low", 32'(uart_tx), 32'h0);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_line", 32'(uart_tx), 32'h1);
      chk("rst_async_done", 32'(tx_done), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_again_status", status, 32'h4);

      // Single byte 0x55: mid-bit samples alternate 0,1,...
      wr(32'h55);
      idle_bus();
      chk("t2_pre_start", 32'(uart_tx), 32'h1);
      @(negedge clk);
      chk("t2_start_fall", 32'(uart_tx), 32'h0);
      repeat (8) @(negedge clk);
      for (int b = 0; b < 10; b++) begin
         chk($sformatf("t2_bit%0d", b), 32'(uart_tx), 32'(b % 2));
         if (b < 9) repeat (16) @(negedge clk);
      end
      repeat (7) @(negedge clk);
      chk("t2_done_early", 32'(tx_done), 32'h0);
      @(negedge clk);
      chk("t2_done_160", 32'(tx_done), 32'h1);
      @(negedge clk);
      chk("t2_done_once", 32'(tx_done), 32'h0);
      wait_idle(400);
      rx_expect("t2_byte", 8'h55);

      // Back-to-back bytes
      wr(32'hA5);
      wr(32'h3C);
      idle_bus();
      chk("t3_status", status, 32'h1);
      wait_idle(800);
      rx_expect("t3_byte0", 8'hA5);
      rx_expect("t3_byte1", 8'h3C);
      chk("t3_status_end", status, 32'h4);

      // Overflow while a frame is in flight
      wr(32'h11);
      idle_bus();
      repeat (3) @(negedge clk);
      for (int i = 1; i <= 5; i++) wr(32'(i));
      idle_bus();
      chk("t4_status_ovf", status, 32'hB);
      wait_idle(2000);
      rx_expect("t4_byte0", 8'h11);
      rx_expect("t4_byte1", 8'h01);
      rx_expect("t4_byte2", 8'h02);
      rx_expect("t4_byte3", 8'h03);
      rx_expect("t4_byte4", 8'h04);
      chk("t4_status_end", status, 32'hC);

      // Clear command: drops overflow, sends nothing
      wr(32'h8000_0000);
      idle_bus();
      chk("t6_clear", status, 32'h4);

      // Push into a full FIFO on the cycle IDLE pops
      wr(32'h21);
      wr(32'h22);
      wr(32'h23);
      wr(32'h24);
      wr(32'h25);
      idle_bus();
      chk("t5_full", status, 32'h3);
      wait_done(400);
      chk("t5_idle_full", status, 32'h2);
      wr(32'h26);
      idle_bus();
      chk("t5_after_push", status, 32'h3);
      wait_idle(2000);
      rx_expect("t5_byte0", 8'h21);
      rx_expect("t5_byte1", 8'h22);
      rx_expect("t5_byte2", 8'h23);
      rx_expect("t5_byte3", 8'h24);
      rx_expect("t5_byte4", 8'h25);
      rx_expect("t5_byte5", 8'h26);
      chk("t5_status_end", status, 32'h4);

      // Decode gating
      we = 1'b1;
      enableUART = 1'b0;
      data = 32'h77;
      @(negedge clk);
      we = 1'b0;
      enableUART = 1'b1;
      data = 32'h78;
      @(negedge clk);
      idle_bus();
      repeat (40) @(negedge clk);
      chk("t6_gate_status", status, 32'h4);
      chk("t6_gate_line", 32'(uart_tx), 32'h1);
      chk("rx_leftover", 32'(rx_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
